// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and the default address width.
package fifo_pkg;

    localparam int unsigned FIFO_ADDRSIZE = 4;
    localparam int unsigned CODE_W        = 32;

    // Width-generic: callers zero-extend into CODE_W bits and truncate the result.
    function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
        logic [CODE_W-1:0] b;
        b = g;
        for (int i = 1; i < int'(CODE_W); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_r2w.sv
// Read-pointer synchronizer into the write clock domain: plain flop chain.
module sync_r2w #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic [WIDTH-1:0] i_rptr,
    output logic [WIDTH-1:0] o_wq_rptr
);

    logic [WIDTH-1:0] r_q [SYNC_STAGES];

    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_q[i] <= '0;
            end
        end else begin
            r_q[0] <= i_rptr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign o_wq_rptr = r_q[SYNC_STAGES-1];

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer, full/almost-full, fill level and sticky overflow for the async FIFO.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int unsigned ADDRSIZE     = FIFO_ADDRSIZE,
    parameter int unsigned AFULL_THRESH = 12,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_wfull;
    logic          r_walmost_full;
    logic [PW-1:0] r_wlevel;
    logic          r_wovf;

    logic [PW-1:0] w_wq2_rptr;
    logic [PW-1:0] w_wbinnext;
    logic [PW-1:0] w_wgraynext;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_next;
    logic [PW-1:0] w_full_cmp;

    sync_r2w #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .wclk      (wclk),
        .wrst      (wrst),
        .i_rptr    (rptr),
        .o_wq_rptr (w_wq2_rptr)
    );

    assign wclken = winc & ~r_wfull;

    // Next pointer and the level it implies against the synchronized read pointer.
    assign w_wbinnext   = r_wbin + PW'(wclken);
    assign w_wgraynext  = PW'(bin2gray(CODE_W'(w_wbinnext)));
    assign w_rbin       = PW'(gray2bin(CODE_W'(w_wq2_rptr)));
    assign w_level_next = w_wbinnext - w_rbin;
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign w_full_cmp   = {~w_wq2_rptr[ADDRSIZE:ADDRSIZE-1], w_wq2_rptr[ADDRSIZE-2:0]};

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_wovf         <= 1'b0;
        end else begin
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wfull        <= (w_wgraynext == w_full_cmp);
            r_walmost_full <= (w_level_next >= PW'(AFULL_THRESH));
            r_wlevel       <= w_level_next;
            if (winc && r_wfull) begin
                r_wovf <= 1'b1;
            end
        end
    end

    assign waddr        = r_wbin[ADDRSIZE-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign wovf         = r_wovf;

endmodule

// File: tb/tb_wptr_full.sv
// Directed vector bench for wptr_full (ADDRSIZE=4, AFULL_THRESH=12, SYNC_STAGES=2).
module tb_wptr_full;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [4:0] rptr;
    logic [3:0] waddr;
    logic       wclken;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       wovf;

    int n_vec = 0;
    int n_err = 0;

    wptr_full #(
        .ADDRSIZE     (4),
        .AFULL_THRESH (12),
        .SYNC_STAGES  (2)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .rptr         (rptr),
        .waddr        (waddr),
        .wclken       (wclken),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       rst;
        logic       inc;
        logic [4:0] rp;
        logic       ck_en;
        logic       en;
        logic [3:0] addr;
        logic [4:0] ptr;
        logic       full;
        logic       af;
        logic [4:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t vq[$];

    function automatic logic [4:0] g(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic void add(input logic rst, input logic inc, input logic [4:0] rp,
                                input logic ck_en, input logic en, input logic [3:0] addr,
                                input logic [4:0] ptr, input logic full, input logic af,
                                input logic [4:0] lvl, input logic ovf);
        vec_t v;
        v.rst = rst; v.inc = inc; v.rp = rp; v.ck_en = ck_en; v.en = en;
        v.addr = addr; v.ptr = ptr; v.full = full; v.af = af; v.lvl = lvl; v.ovf = ovf;
        vq.push_back(v);
    endfunction

    function automatic void add_fill16();
        for (int i = 1; i <= 16; i++) begin
            add(1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 4'(i % 16), g(i), (i == 16), (i >= 12), 5'(i), 1'b0);
        end
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Drive one record, check the combinational enable, clock once, check registered outputs.
    task automatic apply(input vec_t v, input int idx);
        wrst = v.rst;
        winc = v.inc;
        rptr = v.rp;
        #1;
        if (v.ck_en) chk("wclken", idx, 32'(wclken), 32'(v.en));
        @(posedge wclk);
        #1;
        chk("waddr",        idx, 32'(waddr),        32'(v.addr));
        chk("wptr",         idx, 32'(wptr),         32'(v.ptr));
        chk("wfull",        idx, 32'(wfull),        32'(v.full));
        chk("walmost_full", idx, 32'(walmost_full), 32'(v.af));
        chk("wlevel",       idx, 32'(wlevel),       32'(v.lvl));
        chk("wovf",         idx, 32'(wovf),         32'(v.ovf));
    endtask

    task automatic do_reset(input int idx);
        vec_t v;
        v = '{rst: 1'b1, inc: 1'b0, rp: 5'd0, ck_en: 1'b0, en: 1'b0, addr: 4'd0,
              ptr: 5'd0, full: 1'b0, af: 1'b0, lvl: 5'd0, ovf: 1'b0};
        apply(v, idx);
    endtask

    initial begin
        logic [4:0] prev;
        int         rd;
        vec_t       v;

        wrst = 1'b1;
        winc = 1'b1;
        rptr = 5'd0;

        // Reset held two edges with winc high.
        add(1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        add(1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        // Fill to full, then one overflowing request.
        add_fill16();
        add(1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 4'd0, g(16), 1'b1, 1'b1, 5'd16, 1'b1);
        // Release all 16 entries: flags move on the third edge after rptr changes.
        add(1'b0, 1'b0, g(16), 1'b1, 1'b0, 4'd0, g(16), 1'b1, 1'b1, 5'd16, 1'b1);
        add(1'b0, 1'b0, g(16), 1'b1, 1'b0, 4'd0, g(16), 1'b1, 1'b1, 5'd16, 1'b1);
        add(1'b0, 1'b0, g(16), 1'b1, 1'b0, 4'd0, g(16), 1'b0, 1'b0, 5'd0,  1'b1);
        add(1'b0, 1'b0, g(16), 1'b1, 1'b0, 4'd0, g(16), 1'b0, 1'b0, 5'd0,  1'b1);
        // Only reset clears overflow.
        add(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        // Partial drain from full.
        add_fill16();
        add(1'b0, 1'b0, g(4), 1'b1, 1'b0, 4'd0, g(16), 1'b1, 1'b1, 5'd16, 1'b0);
        add(1'b0, 1'b0, g(4), 1'b1, 1'b0, 4'd0, g(16), 1'b1, 1'b1, 5'd16, 1'b0);
        add(1'b0, 1'b0, g(4), 1'b1, 1'b0, 4'd0, g(16), 1'b0, 1'b1, 5'd12, 1'b0);
        add(1'b0, 1'b0, g(5), 1'b1, 1'b0, 4'd0, g(16), 1'b0, 1'b1, 5'd12, 1'b0);
        add(1'b0, 1'b0, g(5), 1'b1, 1'b0, 4'd0, g(16), 1'b0, 1'b1, 5'd12, 1'b0);
        add(1'b0, 1'b0, g(5), 1'b1, 1'b0, 4'd0, g(16), 1'b0, 1'b0, 5'd11, 1'b0);

        foreach (vq[i]) apply(vq[i], i);

        // Wrap: 40 writes, read pointer trailing the write pointer by 3 entries.
        do_reset(1000);
        prev = 5'd0;
        for (int n = 1; n <= 40; n++) begin
            rd   = (n - 4 > 0) ? (n - 4) : 0;
            wrst = 1'b0;
            winc = 1'b1;
            rptr = g(rd);
            #1;
            chk("wrap_wclken", 1000 + n, 32'(wclken), 32'd1);
            @(posedge wclk);
            #1;
            chk("wrap_wptr",  1000 + n, 32'(wptr),  32'(g(n)));
            chk("wrap_waddr", 1000 + n, 32'(waddr), 32'(n % 16));
            chk("wrap_wfull", 1000 + n, 32'(wfull), 32'd0);
            chk("wrap_onebit", 1000 + n, 32'($countones(prev ^ wptr)), 32'd1);
            if (n == 32) begin
                chk("wrap_prev31", 1000 + n, 32'(prev), 32'h10);
                chk("wrap_ptr0",   1000 + n, 32'(wptr), 32'h00);
            end
            prev = wptr;
        end

        // Reset mid-operation at level 10 with a write pending.
        do_reset(2000);
        for (int i = 1; i <= 10; i++) begin
            v = '{rst: 1'b0, inc: 1'b1, rp: 5'd0, ck_en: 1'b1, en: 1'b1, addr: 4'(i),
                  ptr: g(i), full: 1'b0, af: 1'b0, lvl: 5'(i), ovf: 1'b0};
            apply(v, 2000 + i);
        end
        v = '{rst: 1'b1, inc: 1'b1, rp: 5'd0, ck_en: 1'b1, en: 1'b1, addr: 4'd0,
              ptr: 5'd0, full: 1'b0, af: 1'b0, lvl: 5'd0, ovf: 1'b0};
        apply(v, 2011);
        wrst = 1'b0;
        winc = 1'b1;
        #1;
        chk("post_rst_wclken", 2012, 32'(wclken), 32'd1);
        chk("post_rst_waddr",  2012, 32'(waddr),  32'd0);
        @(posedge wclk);
        #1;
        chk("post_rst_waddr_next", 2013, 32'(waddr),  32'd1);
        chk("post_rst_wptr",       2013, 32'(wptr),   32'd1);
        chk("post_rst_wlevel",     2013, 32'(wlevel), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-domain pointer and flag generator for the asynchronous FIFO. It sits directly upstream of the dual-port FIFO memory and drives the memory's write address and write enable. It synchronizes the read-domain Gray pointer into `wclk` and produces the full, almost-full, fill-level and overflow indications. All logic runs on the write clock.

## Interface
- `ADDRSIZE`, 4: memory address width; `DEPTH = 1 << ADDRSIZE`.
- `AFULL_THRESH`, 12: `walmost_full` asserts when `wlevel >= AFULL_THRESH`; legal range 1..DEPTH.
- `SYNC_STAGES`, 2: flop stages in the read-to-write pointer synchronizer; minimum 2.

Ports:
- `wclk` input 1: write clock; the only clock.
- `wrst` input 1: reset, synchronous, active-high.
- `winc` input 1: write request from the producer.
- `rptr` input ADDRSIZE+1: read pointer, Gray coded, registered in the read domain.
- `waddr` output ADDRSIZE: memory write address; the low bits of the binary write pointer.
- `wclken` output 1: memory write enable, `winc & ~wfull`; combinational.
- `wptr` output ADDRSIZE+1: registered Gray write pointer, sent to the read domain.
- `wfull` output 1: FIFO full; registered.
- `walmost_full` output 1: level is at or above `AFULL_THRESH`; registered.
- `wlevel` output ADDRSIZE+1: write-side fill level, 0..DEPTH; registered.
- `wovf` output 1: sticky overflow flag.

## Operation
- State: binary pointer `wbin[ADDRSIZE:0]`, Gray pointer `wptr`, synchronizer chain `wq*_rptr`, and the `wfull`, `walmost_full`, `wlevel` and `wovf` registers.
- Next-state values:
  - `wbinnext = wbin + wclken`, computed modulo 2^(ADDRSIZE+1).
  - `wgraynext = wbinnext ^ (wbinnext >> 1)`.
- Full: `wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]})`, where `A = ADDRSIZE` and `wq2_rptr` is the last synchronizer stage.
- Level: `wlevel <= wbinnext - gray2bin(wq2_rptr)`, computed modulo 2^(ADDRSIZE+1).
  - The result never exceeds DEPTH.
  - It is pessimistic: it over-reports by the reads that have not yet been synchronized.
- Almost-full: `walmost_full <= (wbinnext - gray2bin(wq2_rptr)) >= AFULL_THRESH`.
- Overflow: `wovf` is set on any edge where `winc & wfull`. Only `wrst` clears it.
- A write while full is dropped:
  - `wclken` stays 0.
  - The pointers, `waddr` and memory contents are unchanged.
- `waddr` is `wbin[ADDRSIZE-1:0]` and wraps from DEPTH-1 to 0.
- Pointer wrap: `wbin` wraps from 2·DEPTH-1 to 0. `wptr` changes exactly one bit per accepted write, including across the wrap.
- Reset (`wrst=1` at an edge):
  - `wbin`, `wptr`, every synchronizer stage, `wfull`, `walmost_full`, `wlevel` and `wovf` become 0.
  - Reset overrides a simultaneous `winc`.
  - Reset mid-operation discards the stored level. The read side must be reset in the same window.

## Timing
- Accepted write: `wclken=1` in cycle N. The memory writes at edge N.
  - `waddr`, `wptr` and `wlevel` show the new value after edge N.
  - `wfull` asserts after the same edge N that accepts the DEPTH-th outstanding write. No extra cycle is allowed.
- Read-pointer propagation: a change on `rptr` before edge K appears in `wq2_rptr` after edge K+SYNC_STAGES-1. `wfull`, `wlevel` and `walmost_full` reflect it after edge K+SYNC_STAGES.
- Simultaneous write and read release while full:
  - The write is dropped, because `wfull` is still 1 in that cycle.
  - `wfull` deasserts only after the released read propagates through the synchronizer.
- `wclken` is combinational from `winc` and `wfull`. The producer may hold `winc` high continuously.

## Structure
- Shared package `fifo_pkg` holds:
  - the functions `bin2gray` and `gray2bin`, parameterized on width;
  - the default `ADDRSIZE` constant.
- One sub-module, `sync_r2w`: a SYNC_STAGES-deep flop chain for `rptr` on `wclk` with `wrst`. No logic between the stages.
- Top level holds the pointer, flag and level logic only.

## Test plan
All scenarios use ADDRSIZE=4, AFULL_THRESH=12, SYNC_STAGES=2.
- Reset: hold `wrst`=1 for 2 edges with `winc`=1 -> all outputs 0, `waddr`=0, `wptr`=5'b00000.
- Fill: `rptr`=0, `winc`=1 for 17 cycles:
  - `waddr` steps 0..15 and then holds at 0.
  - `walmost_full` rises after the 12th write.
  - `wfull` rises after the 16th write, with `wlevel`=16.
  - The 17th request gives `wclken`=0 and `wovf`=1.
- Overflow stickiness: after the fill, set `winc`=0 and drive `rptr`=gray(16) -> `wfull` falls 2 edges later, `wlevel`=0, and `wovf` stays 1 until `wrst`.
- Partial drain: full FIFO, `rptr` moves 0 -> gray(4)=5'b00110 -> `wfull` falls and `wlevel`=12 after 2 edges. `walmost_full` stays 1; it drops only when `rptr`=gray(5) gives `wlevel`=11.
- Wrap: 40 writes with `rptr` tracking `wptr` delayed by 3 entries:
  - each `wptr` step differs in exactly one bit;
  - `wptr` steps 5'b10000 -> 5'b00000 when `wbin` wraps 31 -> 0;
  - `wfull` never asserts.
- Reset mid-operation at `wlevel`=10 with `winc`=1 -> after that edge all outputs are 0. The next accepted write goes to `waddr`=0.
